// File: rtl/write_back_stage_n_if.sv
// Bundles the MEM/WB next-instruction inputs, pipeline control and the
// register-file write port seen by the write-back stage.
interface write_back_stage_n_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned ADDR_W  = 6
);
  logic                      Stall;
  logic                      Flush;
  logic                      NextValid;
  logic [NUM_SRC*DATA_W-1:0] NextSrcData;
  logic [DATA_W-1:0]         NextSrcHi;
  logic [SEL_W-1:0]          NextDInSrc;
  logic                      NextRegWE;
  logic [ADDR_W-1:0]         NextRegWAddr;
  logic [1:0]                NextLdSize;
  logic                      NextLdSigned;
  logic [1:0]                NextByteOff;
  logic                      NextDouble;
  logic                      RegWBWE;
  logic [ADDR_W-1:0]         RegWBAddr;
  logic [DATA_W-1:0]         RegWBData;
  logic                      Busy;
  logic                      WBValid;

  modport master (
    output Stall, Flush, NextValid, NextSrcData, NextSrcHi, NextDInSrc, NextRegWE,
           NextRegWAddr, NextLdSize, NextLdSigned, NextByteOff, NextDouble,
    input  RegWBWE, RegWBAddr, RegWBData, Busy, WBValid
  );

  modport slave (
    input  Stall, Flush, NextValid, NextSrcData, NextSrcHi, NextDInSrc, NextRegWE,
           NextRegWAddr, NextLdSize, NextLdSigned, NextByteOff, NextDouble,
    output RegWBWE, RegWBAddr, RegWBData, Busy, WBValid
  );
endinterface

// File: rtl/write_back_stage_n.sv
// Write-back stage: MEM/WB register, result select with big-endian load extraction,
// single-commit writes under stall, flush bubbles and two-cycle register-pair writes.
module write_back_stage_n #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned MEM_SRC = 3
) (
  input logic               clk,
  input logic               reset,
  write_back_stage_n_if.slave wb
);

  typedef enum logic [0:0] {StIdle, StSecond} wbState_t;

  wbState_t                  stateQ, stateD;
  logic                      validQ, validD;
  logic                      weQ, weD;
  logic [NUM_SRC*DATA_W-1:0] srcDataQ, srcDataD;
  logic [DATA_W-1:0]         srcHiQ, srcHiD;
  logic [SEL_W-1:0]          dinSrcQ, dinSrcD;
  logic [ADDR_W-1:0]         addrQ, addrD;
  logic [1:0]                ldSizeQ, ldSizeD;
  logic                      ldSignedQ, ldSignedD;
  logic [1:0]                byteOffQ, byteOffD;
  logic                      doubleQ, doubleD;
  logic                      committedQ, committedD;

  logic              regWe, isPair, pairFirst, isLoad;
  logic [DATA_W-1:0] srcWord, loadWord;
  logic [1:0]        laneIdx;
  logic [7:0]        byteVal;
  logic [DATA_W/2-1:0] halfVal;

  assign regWe     = validQ & weQ & ~committedQ;
  assign isPair    = validQ & weQ & doubleQ;
  assign pairFirst = (stateQ == StIdle) & isPair & ~committedQ;
  assign isLoad    = (dinSrcQ == SEL_W'(MEM_SRC)) & ~doubleQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ     <= StIdle;
      validQ     <= 1'b0;
      weQ        <= 1'b0;
      srcDataQ   <= '0;
      srcHiQ     <= '0;
      dinSrcQ    <= '0;
      addrQ      <= '0;
      ldSizeQ    <= '0;
      ldSignedQ  <= 1'b0;
      byteOffQ   <= '0;
      doubleQ    <= 1'b0;
      committedQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      validQ     <= validD;
      weQ        <= weD;
      srcDataQ   <= srcDataD;
      srcHiQ     <= srcHiD;
      dinSrcQ    <= dinSrcD;
      addrQ      <= addrD;
      ldSizeQ    <= ldSizeD;
      ldSignedQ  <= ldSignedD;
      byteOffQ   <= byteOffD;
      doubleQ    <= doubleD;
      committedQ <= committedD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    validD     = validQ;
    weD        = weQ;
    srcDataD   = srcDataQ;
    srcHiD     = srcHiQ;
    dinSrcD    = dinSrcQ;
    addrD      = addrQ;
    ldSizeD    = ldSizeQ;
    ldSignedD  = ldSignedQ;
    byteOffD   = byteOffQ;
    doubleD    = doubleQ;
    committedD = committedQ;
    if (pairFirst) begin
      // First half of a pair owns the stage; upstream inputs are ignored.
      stateD = StSecond;
    end else begin
      stateD = StIdle;
      if (wb.Flush) begin
        validD     = 1'b0;
        weD        = 1'b0;
        srcDataD   = '0;
        srcHiD     = '0;
        dinSrcD    = '0;
        addrD      = '0;
        ldSizeD    = '0;
        ldSignedD  = 1'b0;
        byteOffD   = '0;
        doubleD    = 1'b0;
        committedD = 1'b0;
      end else if (wb.Stall) begin
        // Held entry only ever writes once: remember that this cycle's write happened.
        committedD = committedQ | regWe;
      end else begin
        validD     = wb.NextValid;
        weD        = wb.NextRegWE;
        srcDataD   = wb.NextSrcData;
        srcHiD     = wb.NextSrcHi;
        dinSrcD    = wb.NextDInSrc;
        addrD      = wb.NextRegWAddr;
        ldSizeD    = wb.NextLdSize;
        ldSignedD  = wb.NextLdSigned;
        byteOffD   = wb.NextByteOff;
        doubleD    = wb.NextDouble;
        committedD = 1'b0;
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    srcWord = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (dinSrcQ == SEL_W'(i)) srcWord = srcDataQ[i*DATA_W +: DATA_W];
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte/half.
  always_comb begin
    laneIdx  = 2'd3 - byteOffQ;
    byteVal  = 8'(srcWord >> {laneIdx, 3'b000});
    halfVal  = byteOffQ[1] ? srcWord[DATA_W/2-1:0] : srcWord[DATA_W-1 -: DATA_W/2];
    loadWord = srcWord;
    case (ldSizeQ)
      2'b10:   loadWord = {{(DATA_W-8){ldSignedQ & byteVal[7]}}, byteVal};
      2'b01:   loadWord = {{(DATA_W/2){ldSignedQ & halfVal[DATA_W/2-1]}}, halfVal};
      default: loadWord = srcWord;
    endcase
  end

  assign wb.RegWBWE   = regWe;
  assign wb.Busy      = pairFirst;
  assign wb.WBValid   = validQ;
  assign wb.RegWBAddr = isPair ? {addrQ[ADDR_W-1:1], ~pairFirst} : addrQ;
  assign wb.RegWBData = pairFirst ? srcHiQ : (isLoad ? loadWord : srcWord);

endmodule

// File: tb/tb_write_back_stage_n.sv
// Randomized bench for write_back_stage_n: directed scenarios plus a scoreboarded stream
// whose expected register-file writes come from a per-instruction reference model.
module tb_write_back_stage_n;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 6;

  typedef struct packed {
    logic         valid;
    logic         we;
    logic         dbl;
    logic         sgn;
    logic [1:0]   sel;
    logic [1:0]   size;
    logic [1:0]   off;
    logic [5:0]   addr;
    logic [127:0] src;
    logic [31:0]  hi;
  } instr_t;

  logic clk;
  logic reset;
  int   passCnt;
  int   totalCnt;

  write_back_stage_n_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ADDR_W(AW)) wbBus ();

  write_back_stage_n #(
    .DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ADDR_W(AW), .MEM_SRC(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (wbBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t t, input logic stall, input logic flush);
    wbBus.Stall        = stall;
    wbBus.Flush        = flush;
    wbBus.NextValid    = t.valid;
    wbBus.NextRegWE    = t.we;
    wbBus.NextDouble   = t.dbl;
    wbBus.NextLdSigned = t.sgn;
    wbBus.NextDInSrc   = t.sel;
    wbBus.NextLdSize   = t.size;
    wbBus.NextByteOff  = t.off;
    wbBus.NextRegWAddr = t.addr;
    wbBus.NextSrcData  = t.src;
    wbBus.NextSrcHi    = t.hi;
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid = 1'b1;
    t.we    = 1'b1;
    t.dbl   = 1'b0;
    t.sgn   = 1'($urandom);
    t.sel   = 2'($urandom);
    t.size  = 2'($urandom);
    t.off   = 2'($urandom);
    t.addr  = 6'($urandom);
    t.src   = {$urandom, $urandom, $urandom, $urandom};
    t.hi    = $urandom;
    return t;
  endfunction

  // Value a single (non-pair) instruction writes: source word, or extracted load data.
  function automatic logic [31:0] ref_single(input instr_t t);
    logic [31:0] w;
    logic [31:0] v;
    w = t.src[32*t.sel +: 32];
    if (t.sel != 2'd3) return w;
    case (t.size)
      2'b10: begin
        v = (w >> (8 * (3 - int'(t.off)))) & 32'hFF;
        if (t.sgn && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = t.off[1] ? (w & 32'hFFFF) : (w >> 16);
        if (t.sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    instr_t idle;
    idle = '0;
    drive(idle, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b0) $display("FAIL reset_we: got %b want 0", wbBus.RegWBWE); else passCnt++;
    totalCnt++; if (wbBus.RegWBAddr !== 6'd0) $display("FAIL reset_addr: got %h want 0", wbBus.RegWBAddr); else passCnt++;
    totalCnt++; if (wbBus.RegWBData !== 32'd0) $display("FAIL reset_data: got %h want 0", wbBus.RegWBData); else passCnt++;
    totalCnt++; if (wbBus.Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", wbBus.Busy); else passCnt++;
    totalCnt++; if (wbBus.WBValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", wbBus.WBValid); else passCnt++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_word();
    instr_t t;
    t = rand_instr();
    t.sel = 2'd1;
    t.src[63:32] = 32'h1234_5678;
    t.addr = 6'd5;
    drive(t, 1'b0, 1'b0);
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b1) $display("FAIL word_we: got %b want 1", wbBus.RegWBWE); else passCnt++;
    totalCnt++; if (wbBus.RegWBAddr !== 6'd5) $display("FAIL word_addr: got %h want 05", wbBus.RegWBAddr); else passCnt++;
    totalCnt++; if (wbBus.RegWBData !== 32'h1234_5678) $display("FAIL word_data: got %h want 12345678", wbBus.RegWBData); else passCnt++;
    for (int i = 0; i < 20; i++) begin
      t = rand_instr();
      t.we = 1'($urandom);
      drive(t, 1'b0, 1'b0);
      step();
      totalCnt++; if (wbBus.RegWBWE !== t.we) $display("FAIL rand_we[%0d]: got %b want %b", i, wbBus.RegWBWE, t.we); else passCnt++;
      totalCnt++; if (wbBus.RegWBAddr !== t.addr) $display("FAIL rand_addr[%0d]: got %h want %h", i, wbBus.RegWBAddr, t.addr); else passCnt++;
      totalCnt++; if (wbBus.RegWBData !== ref_single(t)) $display("FAIL rand_data[%0d]: got %h want %h", i, wbBus.RegWBData, ref_single(t)); else passCnt++;
    end
  endtask

  task automatic test_loads();
    instr_t t;
    logic [1:0]  sizes[3] = '{2'b10, 2'b10, 2'b01};
    logic [1:0]  offs[3]  = '{2'd0, 2'd2, 2'd2};
    logic        sgns[3]  = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exps[3]  = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_7F01};
    for (int i = 0; i < 3; i++) begin
      t = rand_instr();
      t.sel = 2'd3;
      t.src[127:96] = 32'h80FF_7F01;
      t.size = sizes[i];
      t.off = offs[i];
      t.sgn = sgns[i];
      drive(t, 1'b0, 1'b0);
      step();
      totalCnt++; if (wbBus.RegWBData !== exps[i]) $display("FAIL load[%0d]: got %h want %h", i, wbBus.RegWBData, exps[i]); else passCnt++;
    end
  endtask

  task automatic test_stall();
    instr_t a;
    instr_t b;
    int     weCount;
    a = rand_instr();
    a.sel = 2'd0;
    a.addr = 6'd9;
    b = rand_instr();
    b.addr = 6'd33;
    drive(a, 1'b0, 1'b0);
    step();
    weCount = int'(wbBus.RegWBWE);
    drive(b, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      weCount += int'(wbBus.RegWBWE);
      totalCnt++; if (wbBus.RegWBAddr !== 6'd9) $display("FAIL stall_addr[%0d]: got %h want 09", i, wbBus.RegWBAddr); else passCnt++;
      totalCnt++; if (wbBus.RegWBData !== a.src[31:0]) $display("FAIL stall_data[%0d]: got %h want %h", i, wbBus.RegWBData, a.src[31:0]); else passCnt++;
    end
    totalCnt++; if (weCount !== 1) $display("FAIL stall_we_count: got %0d want 1", weCount); else passCnt++;
    drive(b, 1'b0, 1'b0);
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b1 || wbBus.RegWBAddr !== 6'd33) $display("FAIL stall_release: got we=%b addr=%h want we=1 addr=21", wbBus.RegWBWE, wbBus.RegWBAddr); else passCnt++;
  endtask

  task automatic test_double();
    instr_t p;
    instr_t junk;
    instr_t idle;
    idle = '0;
    p = rand_instr();
    p.dbl = 1'b1;
    p.addr = 6'd7;
    p.hi = 32'hAAAA_0000;
    p.sel = 2'd1;
    p.src[63:32] = 32'h0000_BBBB;
    junk = rand_instr();
    junk.addr = 6'd20;
    drive(p, 1'b0, 1'b0);
    step();
    totalCnt++; if (wbBus.Busy !== 1'b1) $display("FAIL dbl1_busy: got %b want 1", wbBus.Busy); else passCnt++;
    totalCnt++; if (wbBus.RegWBWE !== 1'b1) $display("FAIL dbl1_we: got %b want 1", wbBus.RegWBWE); else passCnt++;
    totalCnt++; if (wbBus.RegWBAddr !== 6'd6) $display("FAIL dbl1_addr: got %h want 06", wbBus.RegWBAddr); else passCnt++;
    totalCnt++; if (wbBus.RegWBData !== 32'hAAAA_0000) $display("FAIL dbl1_data: got %h want aaaa0000", wbBus.RegWBData); else passCnt++;
    drive(junk, 1'b0, 1'b1);
    step();
    totalCnt++; if (wbBus.Busy !== 1'b0) $display("FAIL dbl2_busy: got %b want 0", wbBus.Busy); else passCnt++;
    totalCnt++; if (wbBus.RegWBWE !== 1'b1) $display("FAIL dbl2_we: got %b want 1", wbBus.RegWBWE); else passCnt++;
    totalCnt++; if (wbBus.RegWBAddr !== 6'd7) $display("FAIL dbl2_addr: got %h want 07", wbBus.RegWBAddr); else passCnt++;
    totalCnt++; if (wbBus.RegWBData !== 32'h0000_BBBB) $display("FAIL dbl2_data: got %h want 0000bbbb", wbBus.RegWBData); else passCnt++;
    drive(idle, 1'b0, 1'b0);
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b0 || wbBus.WBValid !== 1'b0) $display("FAIL dbl_after: got we=%b valid=%b want 0 0", wbBus.RegWBWE, wbBus.WBValid); else passCnt++;
    // Stall during the second half: exactly two writes, no third.
    drive(p, 1'b0, 1'b0);
    step();
    drive(junk, 1'b1, 1'b0);
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b1 || wbBus.RegWBAddr !== 6'd7) $display("FAIL dbl_stall2: got we=%b addr=%h want we=1 addr=07", wbBus.RegWBWE, wbBus.RegWBAddr); else passCnt++;
    step();
    totalCnt++; if (wbBus.RegWBWE !== 1'b0 || wbBus.Busy !== 1'b0) $display("FAIL dbl_stall3: got we=%b busy=%b want 0 0", wbBus.RegWBWE, wbBus.Busy); else passCnt++;
    drive(idle, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_flush();
    instr_t t;
    for (int i = 0; i < 2; i++) begin
      t = rand_instr();
      drive(t, 1'b0, 1'b0);
      step();
      t = rand_instr();
      drive(t, i == 1, 1'b1);
      step();
      totalCnt++; if (wbBus.WBValid !== 1'b0) $display("FAIL flush_valid[%0d]: got %b want 0", i, wbBus.WBValid); else passCnt++;
      totalCnt++; if (wbBus.RegWBWE !== 1'b0) $display("FAIL flush_we[%0d]: got %b want 0", i, wbBus.RegWBWE); else passCnt++;
      totalCnt++; if (wbBus.RegWBData !== 32'd0) $display("FAIL flush_data[%0d]: got %h want 0", i, wbBus.RegWBData); else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    instr_t      prog[40];
    instr_t      idle;
    instr_t      junk;
    logic [37:0] expQ[$];
    logic [37:0] obsQ[$];
    int          idx;
    int          cycles;
    logic        st;
    logic        fl;
    idle = '0;
    for (int i = 0; i < 40; i++) begin
      prog[i] = rand_instr();
      prog[i].valid = ($urandom_range(0, 9) != 0);
      prog[i].we    = ($urandom_range(0, 7) != 0);
      prog[i].dbl   = ($urandom_range(0, 2) == 0);
    end
    drive(idle, 1'b0, 1'b0);
    step();
    step();
    idx = 0;
    cycles = 0;
    while (idx < 40 && cycles < 1000) begin
      if (wbBus.RegWBWE === 1'b1) obsQ.push_back({wbBus.RegWBAddr, wbBus.RegWBData});
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 6) == 0);
      if (wbBus.Busy === 1'b1) begin
        junk = rand_instr();
        drive(junk, st, fl);
      end else begin
        drive(prog[idx], st, fl);
        if (fl) idx++;
        else if (!st) begin
          if (prog[idx].valid && prog[idx].we) begin
            if (prog[idx].dbl) begin
              expQ.push_back({prog[idx].addr & 6'h3E, prog[idx].hi});
              expQ.push_back({prog[idx].addr | 6'h01, prog[idx].src[32*prog[idx].sel +: 32]});
            end else begin
              expQ.push_back({prog[idx].addr, ref_single(prog[idx])});
            end
          end
          idx++;
        end
      end
      step();
      cycles++;
    end
    totalCnt++; if (idx !== 40) $display("FAIL b2b_timeout: issued %0d want 40", idx); else passCnt++;
    drive(idle, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (wbBus.RegWBWE === 1'b1) obsQ.push_back({wbBus.RegWBAddr, wbBus.RegWBData});
      step();
    end
    totalCnt++; if (obsQ.size() !== expQ.size()) $display("FAIL b2b_count: got %0d want %0d", obsQ.size(), expQ.size()); else passCnt++;
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      totalCnt++; if (obsQ[i] !== expQ[i]) $display("FAIL b2b_write[%0d]: got %h want %h", i, obsQ[i], expQ[i]); else passCnt++;
    end
  endtask

  task automatic test_reset_mid_pair();
    instr_t p;
    instr_t idle;
    idle = '0;
    p = rand_instr();
    p.dbl = 1'b1;
    p.addr = 6'd7;
    drive(p, 1'b0, 1'b0);
    step();
    totalCnt++; if (wbBus.Busy !== 1'b1) $display("FAIL rst_pair_busy: got %b want 1", wbBus.Busy); else passCnt++;
    #2 reset = 1'b0;
    #1;
    totalCnt++; if (wbBus.RegWBWE !== 1'b0 || wbBus.Busy !== 1'b0 || wbBus.WBValid !== 1'b0) $display("FAIL rst_pair_ctl: got we=%b busy=%b valid=%b want 0 0 0", wbBus.RegWBWE, wbBus.Busy, wbBus.WBValid); else passCnt++;
    totalCnt++; if (wbBus.RegWBAddr !== 6'd0 || wbBus.RegWBData !== 32'd0) $display("FAIL rst_pair_bus: got addr=%h data=%h want 0 0", wbBus.RegWBAddr, wbBus.RegWBData); else passCnt++;
    drive(idle, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      totalCnt++; if (wbBus.RegWBWE !== 1'b0) $display("FAIL rst_pair_after[%0d]: got we=%b addr=%h want we=0", i, wbBus.RegWBWE, wbBus.RegWBAddr); else passCnt++;
    end
  endtask

  initial begin
    passCnt = 0;
    totalCnt = 0;
    reset = 1'b0;
    test_reset();
    test_word();
    test_loads();
    test_stall();
    test_double();
    test_flush();
    test_back_to_back();
    test_reset_mid_pair();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
